// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state, size codes and base address for the memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h8000_0000;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port byte-masked word store with synchronous write and combinational read
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_resp.sv
// mem_resp: fixed-latency IFU/LSU memory responder with LSU-priority arbitration
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        err
);
  localparam int AW = $clog2(MEM_WORDS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic lsu_q, legal_q;
  logic [1:0] lo_q;
  logic [31:0] word_q, addr, off, rd;
  logic sel_lsu, acc, legal, we, unused_size;
  assign unused_size = ^io_lsu_size;
  assign sel_lsu = io_lsu_reqValid;
  assign acc = state == IDLE && (io_ifu_reqValid || io_lsu_reqValid);
  assign addr = sel_lsu ? io_lsu_addr : io_ifu_addr;
  assign off = addr - BASE_ADDR;
  assign legal = addr >= BASE_ADDR && (off >> 2) < 32'(MEM_WORDS) && (sel_lsu || addr[1:0] == 2'b00);
  assign we = acc && sel_lsu && io_lsu_wen && legal;
  mem_array #(.WORDS(MEM_WORDS), .AW(AW)) u_arr (
    .clk(clock),
    .we(we),
    .addr(off[AW+1:2]),
    .wdata(io_lsu_wdata << {addr[1:0], 3'b000}),
    .wmask(io_lsu_wmask << addr[1:0]),
    .rdata(rd)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lsu_q <= 1'b0;
      legal_q <= 1'b0;
      lo_q <= '0;
      word_q <= '0;
    end else begin
      state <= state_n;
      cnt <= acc ? 4'(LATENCY - 1) : state == WAIT ? cnt - 4'd1 : cnt;
      if (acc) begin
        lsu_q <= sel_lsu;
        legal_q <= legal;
        lo_q <= addr[1:0];
        word_q <= legal ? rd : '0;
      end
    end
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = acc ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
    else if (state == WAIT) state_n = cnt <= 4'd1 ? RESP : WAIT;
  end
  assign io_ifu_respValid = state == RESP && !lsu_q;
  assign io_lsu_respValid = state == RESP && lsu_q;
  assign io_ifu_rdata = io_ifu_respValid ? word_q : '0;
  assign io_lsu_rdata = io_lsu_respValid ? word_q >> {lo_q, 3'b000} : '0;
  assign err = state == RESP && !legal_q;
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: randomized self-checking bench for mem_resp against a word-array reference model
module tb_mem_resp;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic ifu_req = 0, lsu_req = 0, lsu_wen = 0;
  logic [31:0] ifu_addr = 0, lsu_addr = 0, lsu_wdata = 0;
  logic [1:0] lsu_size = 0;
  logic [3:0] lsu_wmask = 0;
  logic ifu_rv, lsu_rv, err;
  logic [31:0] ifu_rd, lsu_rd;
  logic b_ifu_req = 0, b_lsu_req = 0, b_lsu_wen = 0;
  logic [31:0] b_ifu_addr = 0, b_lsu_addr = 0, b_lsu_wdata = 0;
  logic [1:0] b_lsu_size = 0;
  logic [3:0] b_lsu_wmask = 0;
  logic b_ifu_rv, b_lsu_rv, b_err;
  logic [31:0] b_ifu_rd, b_lsu_rd;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mdl [int];
  mem_resp #(.LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(ifu_req), .io_ifu_addr(ifu_addr),
    .io_ifu_respValid(ifu_rv), .io_ifu_rdata(ifu_rd),
    .io_lsu_reqValid(lsu_req), .io_lsu_addr(lsu_addr), .io_lsu_size(lsu_size),
    .io_lsu_wen(lsu_wen), .io_lsu_wdata(lsu_wdata), .io_lsu_wmask(lsu_wmask),
    .io_lsu_respValid(lsu_rv), .io_lsu_rdata(lsu_rd), .err(err)
  );
  mem_resp #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(b_ifu_req), .io_ifu_addr(b_ifu_addr),
    .io_ifu_respValid(b_ifu_rv), .io_ifu_rdata(b_ifu_rd),
    .io_lsu_reqValid(b_lsu_req), .io_lsu_addr(b_lsu_addr), .io_lsu_size(b_lsu_size),
    .io_lsu_wen(b_lsu_wen), .io_lsu_wdata(b_lsu_wdata), .io_lsu_wmask(b_lsu_wmask),
    .io_lsu_respValid(b_lsu_rv), .io_lsu_rdata(b_lsu_rd), .err(b_err)
  );
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  function automatic bit legal_m(bit lsu, logic [31:0] a);
    return a >= 32'h8000_0000 && (a - 32'h8000_0000) / 4 < 4096 && (lsu || a % 4 == 0);
  endfunction
  function automatic logic [31:0] load_m(bit lsu, logic [31:0] a);
    int idx;
    if (!legal_m(lsu, a)) return 32'h0;
    idx = int'((a - 32'h8000_0000) / 4);
    return lsu ? mdl[idx] >> (8 * (a % 4)) : mdl[idx];
  endfunction
  function automatic void store_m(logic [31:0] a, logic [31:0] d, logic [3:0] m);
    int idx, lo;
    logic [31:0] w;
    if (!legal_m(1'b1, a)) return;
    idx = int'((a - 32'h8000_0000) / 4);
    lo = int'(a % 4);
    w = mdl.exists(idx) ? mdl[idx] : 32'h0;
    for (int k = 0; k < 4; k++)
      if (m[k] && lo + k < 4) w[8*(lo+k) +: 8] = d[8*k +: 8];
    mdl[idx] = w;
  endfunction
  task automatic run_txn(input bit lsu, input logic [31:0] a, input bit wen, input logic [31:0] d,
                         input logic [3:0] m, output int lat, output logic [31:0] rd,
                         output logic er, output bit clean);
    clean = 1;
    if (lsu) begin
      lsu_req = 1; lsu_addr = a; lsu_size = 2'd2; lsu_wen = wen; lsu_wdata = d; lsu_wmask = m;
    end else begin
      ifu_req = 1; ifu_addr = a;
    end
    step;
    if (lsu && wen) store_m(a, d, m);
    ifu_req = 0; lsu_req = 0;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom); lsu_wen = 1'($urandom);
    lat = 1;
    while (!(lsu ? lsu_rv : ifu_rv) && lat < 20) begin
      if (ifu_rv || lsu_rv || err || ifu_rd != 0 || lsu_rd != 0) clean = 0;
      step;
      lat++;
    end
    rd = lsu ? lsu_rd : ifu_rd;
    er = err;
    if (lsu ? ifu_rv : lsu_rv) clean = 0;
    step;
    if (ifu_rv || lsu_rv || err || ifu_rd != 0 || lsu_rd != 0) clean = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    step;
    step;
    n_cmp++;
    if ({ifu_rv, lsu_rv, err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000", {ifu_rv, lsu_rv, err});
    end
    n_cmp++;
    if (ifu_rd !== 32'h0 || lsu_rd !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata got %h/%h want 0/0", ifu_rd, lsu_rd);
    end
    n_cmp++;
    if ({b_ifu_rv, b_lsu_rv, b_err} !== 3'b000 || b_ifu_rd !== 32'h0 || b_lsu_rd !== 32'h0) begin
      n_bad++; $display("FAIL reset_lat1 got %b %h %h want 000 0 0", {b_ifu_rv, b_lsu_rv, b_err}, b_ifu_rd, b_lsu_rd);
    end
    reset = 0;
    step;
  endtask
  task automatic test_ifu_fetch;
    int lat; logic [31:0] rd; logic er; bit cl;
    run_txn(1, 32'h8000_0000, 1, 32'h0000_0513, 4'hF, lat, rd, er, cl);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0 || !cl) begin
      n_bad++; $display("FAIL preload_store got lat=%0d err=%b clean=%0d want 2 0 1", lat, er, cl);
    end
    run_txn(0, 32'h8000_0000, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (lat !== 2) begin n_bad++; $display("FAIL ifu_latency got %0d want 2", lat); end
    n_cmp++;
    if (rd !== 32'h0000_0513) begin n_bad++; $display("FAIL ifu_rdata got %h want 00000513", rd); end
    n_cmp++;
    if (er !== 1'b0 || !cl) begin n_bad++; $display("FAIL ifu_pulse got err=%b clean=%0d want 0 1", er, cl); end
  endtask
  task automatic test_byte_store;
    int lat; logic [31:0] rd; logic er; bit cl;
    run_txn(1, 32'h8000_0004, 1, 32'h0011_2233, 4'hF, lat, rd, er, cl);
    run_txn(1, 32'h8000_0006, 1, 32'h5555_55AB, 4'b0001, lat, rd, er, cl);
    run_txn(1, 32'h8000_0006, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'h0000_00AB || rd !== load_m(1, 32'h8000_0006)) begin
      n_bad++; $display("FAIL byte_load got %h want 000000ab", rd);
    end
    run_txn(1, 32'h8000_0004, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'h00AB_2233) begin n_bad++; $display("FAIL byte_neighbours got %h want 00ab2233", rd); end
    run_txn(1, 32'h8000_0007, 1, 32'hDDCC_BBAA, 4'hF, lat, rd, er, cl);
    run_txn(1, 32'h8000_0004, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'hAAAB_2233 || rd !== load_m(1, 32'h8000_0004)) begin
      n_bad++; $display("FAIL boundary_drop got %h want aaab2233", rd);
    end
    run_txn(1, 32'h8000_0007, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'h0000_00AA || lat !== 2 || er !== 1'b0 || !cl) begin
      n_bad++; $display("FAIL byte3_load got %h lat=%0d err=%b want 000000aa 2 0", rd, lat, er);
    end
  endtask
  task automatic test_arbitration;
    int lc = -1, ic = -1;
    logic [31:0] lrd = 0, ird = 0;
    bit both = 0;
    ifu_req = 1; ifu_addr = 32'h8000_0000;
    lsu_req = 1; lsu_addr = 32'h8000_0004; lsu_wen = 0; lsu_size = 2'd2;
    for (int c = 1; c <= 12; c++) begin
      step;
      lsu_req = 0; lsu_addr = $urandom;
      if (lsu_rv && ifu_rv) both = 1;
      if (lsu_rv && lc < 0) begin lc = c; lrd = lsu_rd; end
      if (ifu_rv && ic < 0) begin ic = c; ird = ifu_rd; ifu_req = 0; end
    end
    ifu_req = 0;
    n_cmp++;
    if (lc !== 2 || lrd !== load_m(1, 32'h8000_0004)) begin
      n_bad++; $display("FAIL arb_lsu_first got cycle=%0d data=%h want 2 %h", lc, lrd, load_m(1, 32'h8000_0004));
    end
    n_cmp++;
    if (ic !== 5 || ird !== load_m(0, 32'h8000_0000) || both) begin
      n_bad++; $display("FAIL arb_ifu_next got cycle=%0d data=%h overlap=%0d want 5 %h 0", ic, ird, both, load_m(0, 32'h8000_0000));
    end
  endtask
  task automatic test_illegal;
    int lat; logic [31:0] rd; logic er; bit cl;
    run_txn(1, 32'h7FFF_FFFC, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b1 || !cl) begin
      n_bad++; $display("FAIL illegal_lsu_low got lat=%0d rd=%h err=%b clean=%0d want 2 0 1 1", lat, rd, er, cl);
    end
    run_txn(0, 32'h8000_0002, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b1 || !cl) begin
      n_bad++; $display("FAIL illegal_ifu_misalign got lat=%0d rd=%h err=%b clean=%0d want 2 0 1 1", lat, rd, er, cl);
    end
    run_txn(1, 32'h8000_4000, 1, 32'h1234_5678, 4'hF, lat, rd, er, cl);
    n_cmp++;
    if (lat !== 2 || er !== 1'b1 || !cl) begin
      n_bad++; $display("FAIL illegal_store_end got lat=%0d err=%b want 2 1", lat, er);
    end
    run_txn(1, 32'h8000_3FFC, 1, 32'hCAFE_F00D, 4'hF, lat, rd, er, cl);
    run_txn(0, 32'h8000_3FFC, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL last_word got %h err=%b lat=%0d want cafef00d 0 2", rd, er, lat);
    end
  endtask
  task automatic test_reset_abort;
    int seen = 0, lat; logic [31:0] rd; logic er; bit cl;
    lsu_req = 1; lsu_addr = 32'h8000_0000; lsu_wen = 0;
    step;
    lsu_req = 0; reset = 1;
    step;
    reset = 0;
    for (int c = 0; c < 8; c++) begin
      if (ifu_rv || lsu_rv || err) seen++;
      step;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL abort_no_resp got %0d response cycles want 0", seen); end
    lsu_req = 1; lsu_addr = 32'h8000_0008; lsu_wen = 1; lsu_wdata = 32'h1357_9BDF; lsu_wmask = 4'hF;
    step;
    store_m(32'h8000_0008, 32'h1357_9BDF, 4'hF);
    lsu_req = 0; reset = 1;
    step;
    reset = 0;
    step;
    run_txn(1, 32'h8000_0008, 0, 0, 0, lat, rd, er, cl);
    n_cmp++;
    if (rd !== 32'h1357_9BDF || lat !== 2 || er !== 1'b0 || !cl) begin
      n_bad++; $display("FAIL abort_store_kept got %h lat=%0d err=%b want 13579bdf 2 0", rd, lat, er);
    end
  endtask
  task automatic test_random;
    int lat; logic [31:0] rd, a, d; logic er; bit cl, lsu, wen;
    logic [3:0] m;
    logic [31:0] bad_addr [4] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'hFFFF_FFF0, 32'h0};
    for (int i = 0; i < 16; i++) run_txn(1, 32'h8000_0000 + 32'(4 * i), 1, $urandom, 4'hF, lat, rd, er, cl);
    for (int i = 0; i < 40; i++) begin
      lsu = 1'($urandom);
      wen = lsu && 1'($urandom);
      a = ($urandom % 8 == 0) ? bad_addr[$urandom % 4] : 32'h8000_0000 + ($urandom % 64);
      d = $urandom;
      m = 4'($urandom);
      run_txn(lsu, a, wen, d, m, lat, rd, er, cl);
      n_cmp++;
      if (lat !== 2 || er !== !legal_m(lsu, a) || !cl) begin
        n_bad++; $display("FAIL rand_ctrl #%0d addr=%h got lat=%0d err=%b clean=%0d want 2 %b 1", i, a, lat, er, cl, !legal_m(lsu, a));
      end
      if (!wen || !legal_m(lsu, a)) begin
        n_cmp++;
        if (rd !== load_m(lsu, a)) begin
          n_bad++; $display("FAIL rand_data #%0d lsu=%0d addr=%h got %h want %h", i, lsu, a, rd, load_m(lsu, a));
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    b_lsu_req = 1; b_lsu_addr = 32'h8000_0000; b_lsu_wen = 1; b_lsu_wdata = $urandom; b_lsu_wmask = 4'hF; b_lsu_size = 2'd2;
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (b_lsu_rv !== 1'(c % 2) || b_err !== 1'b0) begin
        n_bad++; $display("FAIL b2b_cycle%0d got rv=%b err=%b want %0d 0", c, b_lsu_rv, b_err, c % 2);
      end
      step;
    end
    b_lsu_req = 0;
    step;
  endtask
  initial begin
    test_reset;
    test_ifu_fetch;
    test_byte_store;
    test_arbitration;
    test_illegal;
    test_reset_abort;
    test_random;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameters SHALL be:
- MEM_WORDS, 4096, word depth of the backing array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from acceptance to respValid; legal range 1..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- io_ifu_reqValid  in  1  fetch request.
- io_ifu_addr  in  32  fetch byte address.
- io_ifu_respValid  out  1  fetch response pulse.
- io_ifu_rdata  out  32  fetch word.
- io_lsu_reqValid  in  1  load/store request.
- io_lsu_addr  in  32  byte address.
- io_lsu_size  in  2  0 byte, 1 half, 2 word.
- io_lsu_wen  in  1  1 store, 0 load.
- io_lsu_wdata  in  32  store data, LSB-aligned.
- io_lsu_wmask  in  4  byte mask, LSB-aligned.
- io_lsu_respValid  out  1  load/store response pulse.
- io_lsu_rdata  out  32  load data, LSB-aligned.
- err  out  1  one-cycle pulse with a response to an illegal access.

Function
REQ-003 States SHALL be IDLE, WAIT and RESP, with exactly one transaction in flight at a time.
REQ-004 In IDLE, a request SHALL be accepted on a cycle with reqValid high; the responder SHALL capture the port, addr, size, wen, wdata and wmask, and SHALL move to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-005 On simultaneous IFU and LSU requests in IDLE, the LSU SHALL be accepted; the IFU request SHALL stay pending and SHALL be accepted in the next IDLE cycle if still asserted.
REQ-006 A latency counter SHALL load LATENCY-1 on acceptance and decrement in WAIT; RESP SHALL be entered when the count reaches 1, so that respValid rises exactly LATENCY cycles after the acceptance edge.
REQ-007 In RESP, only the accepted port's respValid SHALL be high, for exactly one cycle, with rdata valid in that same cycle; the next state SHALL be IDLE and no acceptance SHALL occur in RESP.
REQ-008 The word index SHALL be (addr-BASE_ADDR)>>2; an access SHALL be legal when addr>=BASE_ADDR and index<MEM_WORDS.
REQ-009 An IFU access SHALL additionally require addr[1:0]==0.
REQ-010 The array SHALL be read at acceptance and the word held in a register; io_lsu_rdata SHALL be that word shifted right by 8*addr[1:0], zero-filled; io_ifu_rdata SHALL be the unshifted word.
REQ-011 A store SHALL write at the acceptance edge, using wdata<<(8*addr[1:0]) and (wmask<<addr[1:0]) truncated to 4 bits; bytes beyond the word boundary SHALL be dropped silently.
REQ-012 An illegal access SHALL perform no write, SHALL return rdata=0, and SHALL still complete with respValid; err SHALL pulse in that RESP cycle.
REQ-013 Outside RESP, both rdata outputs SHALL be 0.
REQ-014 Input changes after acceptance SHALL have no effect on the in-flight transaction.

Reset
REQ-015 Reset SHALL force IDLE, counter 0, both respValid low, err low and rdata 0, with these values visible in the cycle after reset is sampled.
REQ-016 Reset during WAIT or RESP SHALL abort the transaction with no response; a store already committed at acceptance SHALL remain written.
REQ-017 Array contents SHALL NOT be cleared by reset.

Structure
REQ-018 The state enum, the size codes (SIZE_B, SIZE_H, SIZE_W) and BASE_ADDR's default SHALL live in the shared SoC package.
REQ-019 The storage SHALL be one sub-module, mem_array: single-port, synchronous write, byte-masked, combinational read, MEM_WORDS deep.
REQ-020 mem_resp SHALL contain the FSM, arbiter, counter, address decode and alignment shifters.

Verification
REQ-021 LATENCY=2: IFU req at 0x8000_0000 in cycle 0, with word 0x0000_0513 preloaded -> io_ifu_respValid high in cycle 2 only, rdata 0x0000_0513.
REQ-022 LSU store size 0, addr 0x8000_0006, wdata 0xAB, wmask 0001 -> word 1 byte 2 becomes 0xAB, other bytes unchanged; a following load byte at the same address returns 0x0000_00AB.
REQ-023 IFU and LSU req in the same cycle -> LSU responds first; IFU is accepted in the first IDLE cycle afterwards, and its respValid arrives LATENCY cycles after that acceptance.
REQ-024 LSU load at 0x7FFF_FFFC -> respValid with rdata 0 and err pulse; IFU at 0x8000_0002 -> same outcome.
REQ-025 Reset asserted in the cycle after accepting a load -> no respValid ever for that load; the next request completes normally with LATENCY timing.
REQ-026 LATENCY=1 back-to-back LSU requests held high -> respValid in cycles 1, 3, 5 (one-cycle IDLE gap each time).
